// File: rtl/store_merge_unit.sv
// MEM-stage store unit: turns SW/SH/SB into word writes on a word-only data memory,
// using read-modify-write for sub-word stores and flagging misaligned stores.
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  store_instr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        align_err
);

    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SB = 6'h28;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] addr_r;
    logic [5:0]  instr_r;
    logic [31:0] wdata_r;
    logic [31:0] merged_r;
    logic        accept_s;

    // Replace one byte (SB) or halfword (SH) lane of the memory word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] rdata,
                                               input logic [31:0] src,
                                               input logic [5:0]  instr,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = rdata;
        if (instr == OP_SH) begin
            if (lane[1]) begin
                w[31:16] = src[15:0];
            end else begin
                w[15:0] = src[15:0];
            end
        end else begin
            case (lane)
                2'd0:    w[7:0]   = src[7:0];
                2'd1:    w[15:8]  = src[7:0];
                2'd2:    w[23:16] = src[7:0];
                2'd3:    w[31:24] = src[7:0];
                default: w        = rdata;
            endcase
        end
        return w;
    endfunction

    assign accept_s = req_valid && (state_r == IDLE) && !reset;

    // State register and request/merge latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            addr_r   <= 32'h0000_0000;
            instr_r  <= 6'd0;
            wdata_r  <= 32'h0000_0000;
            merged_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                addr_r  <= addr;
                instr_r <= store_instr;
                wdata_r <= wdata;
            end
            if (state_r == MERGE) begin
                merged_r <= merge_lane(mem_rdata, wdata_r, instr_r, addr_r[1:0]);
            end
        end
    end

    // Next-state decode, including alignment classification of the incoming request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (store_instr == OP_SW) begin
                        state_next_s = (addr[1:0] == 2'b00) ? WRITE : ERR;
                    end else if (store_instr == OP_SH) begin
                        state_next_s = (addr[0] == 1'b0) ? READ : ERR;
                    end else if (store_instr == OP_SB) begin
                        state_next_s = READ;
                    end else begin
                        // Unknown opcodes still complete, but never touch memory.
                        state_next_s = WRITE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = MERGE;
            MERGE:   state_next_s = WRITE;
            WRITE:   state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from state; reset forces every output low in the same cycle.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = 32'h0000_0000;
        done      = 1'b0;
        align_err = 1'b0;
        if (!reset) begin
            case (state_r)
                IDLE: begin
                    req_ready = 1'b1;
                end
                READ: begin
                    busy      = 1'b1;
                    mem_addr  = {addr_r[31:2], 2'b00};
                    mem_rd_en = 1'b1;
                end
                MERGE: begin
                    busy     = 1'b1;
                    mem_addr = {addr_r[31:2], 2'b00};
                end
                WRITE: begin
                    busy      = 1'b1;
                    mem_addr  = {addr_r[31:2], 2'b00};
                    done      = 1'b1;
                    mem_wr_en = (instr_r == OP_SW) || (instr_r == OP_SH) || (instr_r == OP_SB);
                    if ((instr_r == OP_SH) || (instr_r == OP_SB)) begin
                        mem_wdata = merged_r;
                    end else begin
                        mem_wdata = wdata_r;
                    end
                end
                ERR: begin
                    busy      = 1'b1;
                    mem_addr  = {addr_r[31:2], 2'b00};
                    align_err = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            req_ready = 1'b0;
        end
    end

endmodule
